// File: rtl/ibus_sched_pkg.sv
// Shared definitions for the ibus scheduler: FSM state encoding and abort data.
package ibus_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Read data returned to the requester when the watchdog aborts a fetch.
    localparam logic [31:0] TIMEOUT_RDT = 32'hFFFF_FFFF;

endpackage

// File: rtl/ibus_sched_prio_pick.sv
// Fixed-priority picker: the lowest-indexed request that survives the mask wins.
// The output is one-hot, or zero when no unmasked request is present.
module prio_pick #(
    parameter int N = 3
) (
    input  logic [N-1:0] req,
    input  logic [N-1:0] mask,
    output logic [N-1:0] pick
);

    logic [N-1:0] cand;
    logic         found;

    // Scan from index 0 upward and keep only the first candidate.
    always_comb begin
        cand  = req & mask;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (cand[i] && !found) begin
                pick[i] = 1'b1;
                found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ibus_sched.sv
// N-requester scheduler in front of the single SPI-flash XiP controller.
// Port 0 (CPU) has fixed priority, bounded by a starvation guard; a watchdog
// aborts fetches the controller never acknowledges. Ack/data outputs are zero
// outside the completion cycle so several schedulers can be OR-combined.
module ibus_sched
    import ibus_sched_pkg::*;
#(
    parameter int N          = 3,
    parameter int MAX_STARVE = 4,
    parameter int TIMEOUT    = 1023
) (
    input  logic            wb_clk,
    input  logic            wb_rst,
    input  logic [N-1:0]    req_cyc,
    input  logic [32*N-1:0] req_adr,
    output logic [N-1:0]    req_ack,
    output logic [32*N-1:0] req_rdt,
    output logic            x_cyc,
    output logic [31:0]     x_adr,
    input  logic            x_ack,
    input  logic [31:0]     x_rdt,
    output logic [N-1:0]    grant,
    output logic            busy,
    output logic            timeout_err
);

    localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    state_t          state;
    state_t          state_next;
    logic [3:0]      starve;
    logic [WD_W-1:0] wdog;
    logic [N-1:0]    win;
    logic [N-1:0]    pick_mask;
    logic [31:0]     win_adr;
    logic            others_req;
    logic            starve_mode;
    logic            wd_expired;

    assign others_req  = |req_cyc[N-1:1];
    assign starve_mode = (starve == 4'(MAX_STARVE)) && others_req;
    // In starvation mode port 0 is masked out so the next lower port wins.
    assign pick_mask   = starve_mode ? {{(N-1){1'b1}}, 1'b0} : {N{1'b1}};
    assign wd_expired  = (TIMEOUT != 0) && (wdog == WD_W'(TIMEOUT));
    assign busy        = (state != IDLE);

    prio_pick #(.N(N)) u_pick (
        .req  (req_cyc),
        .mask (pick_mask),
        .pick (win)
    );

    // Route the winning requester's address toward the controller.
    always_comb begin
        win_adr = '0;
        for (int i = 0; i < N; i++) begin
            if (win[i]) win_adr = req_adr[32*i +: 32];
        end
    end

    // State register.
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) state <= IDLE;
        else        state <= state_next;
    end

    // Next state and the combinational completion outputs; an ack is only
    // forwarded if the owner still holds cyc, otherwise it is dropped.
    always_comb begin
        state_next  = state;
        req_ack     = '0;
        req_rdt     = '0;
        timeout_err = 1'b0;
        case (state)
            IDLE: begin
                if (|req_cyc) state_next = BUSY;
            end
            BUSY: begin
                if (x_ack) begin
                    state_next = DONE;
                    for (int i = 0; i < N; i++) begin
                        if (grant[i] && req_cyc[i]) begin
                            req_ack[i]          = 1'b1;
                            req_rdt[32*i +: 32] = x_rdt;
                        end
                    end
                end else if (wd_expired) begin
                    state_next  = DONE;
                    timeout_err = 1'b1;
                    for (int i = 0; i < N; i++) begin
                        if (grant[i] && req_cyc[i]) begin
                            req_ack[i]          = 1'b1;
                            req_rdt[32*i +: 32] = TIMEOUT_RDT;
                        end
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Grant, controller request, watchdog and starvation bookkeeping.
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            grant  <= '0;
            x_cyc  <= 1'b0;
            x_adr  <= '0;
            starve <= '0;
            wdog   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    wdog <= '0;
                    if (|req_cyc) begin
                        grant <= win;
                        x_adr <= win_adr;
                        x_cyc <= 1'b1;
                        if (win[0]) begin
                            if (others_req && starve != 4'd15) starve <= starve + 4'd1;
                        end else begin
                            starve <= '0;
                        end
                    end
                end
                BUSY: begin
                    if (state_next == DONE) begin
                        grant <= '0;
                        x_cyc <= 1'b0;
                        wdog  <= '0;
                    end else begin
                        wdog  <= wdog + WD_W'(1);
                    end
                end
                default: begin
                    grant <= '0;
                    x_cyc <= 1'b0;
                    wdog  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ibus_sched.sv
// Directed bench for ibus_sched (N=3, MAX_STARVE=4, TIMEOUT=16).
module tb_ibus_sched;

    logic        wb_clk = 1'b0;
    logic        wb_rst = 1'b1;
    logic [2:0]  req_cyc = '0;
    logic [95:0] req_adr = '0;
    logic [2:0]  req_ack;
    logic [95:0] req_rdt;
    logic        x_cyc;
    logic [31:0] x_adr;
    logic        x_ack = 1'b0;
    logic [31:0] x_rdt = '0;
    logic [2:0]  grant;
    logic        busy;
    logic        timeout_err;

    int checks   = 0;
    int failures = 0;

    ibus_sched #(.N(3), .MAX_STARVE(4), .TIMEOUT(16)) dut (
        .wb_clk      (wb_clk),
        .wb_rst      (wb_rst),
        .req_cyc     (req_cyc),
        .req_adr     (req_adr),
        .req_ack     (req_ack),
        .req_rdt     (req_rdt),
        .x_cyc       (x_cyc),
        .x_adr       (x_adr),
        .x_ack       (x_ack),
        .x_rdt       (x_rdt),
        .grant       (grant),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 wb_clk = ~wb_clk;

    initial begin
        #200000;
        $display("FAIL watchdog_time sim did not finish got=running exp=finished");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge wb_clk);
        #2;
    endtask

    function automatic int idx_of(input logic [2:0] g);
        return g[2] ? 2 : (g[1] ? 1 : 0);
    endfunction

    // One transaction, entered in an IDLE cycle with requests already driven;
    // the controller acks in the first BUSY cycle. Returns in the next IDLE cycle.
    task automatic xact(input string tag, input logic [2:0] g, input logic [31:0] d);
        #1 chk({tag, "_idle"}, 32'(busy), 32'd0);
        nxt();
        chk({tag, "_grant"}, 32'(grant), 32'(g));
        chk({tag, "_xcyc"}, 32'(x_cyc), 32'd1);
        x_ack = 1'b1;
        x_rdt = d;
        #1 chk({tag, "_ack"}, 32'(req_ack), 32'(g));
        chk({tag, "_rdt"}, req_rdt[32*idx_of(g) +: 32], d);
        nxt();
        x_ack = 1'b0;
        x_rdt = '0;
        #1 chk({tag, "_done_xcyc"}, 32'(x_cyc), 32'd0);
        chk({tag, "_done_grant"}, 32'(grant), 32'd0);
        nxt();
    endtask

    initial begin
        logic [2:0] sq [6];
        sq = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b001};

        // Reset state
        #3;
        chk("rst_xcyc", 32'(x_cyc), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ack", 32'(req_ack), 32'd0);
        chk("rst_xadr", x_adr, 32'd0);
        nxt();
        nxt();
        wb_rst = 1'b0;

        // Single request on port 1, acked 5 cycles into BUSY
        req_cyc = 3'b010;
        req_adr[63:32] = 32'h0010_0040;
        #1 chk("t1_xcyc_req_cycle", 32'(x_cyc), 32'd0);
        nxt();
        chk("t1_xcyc", 32'(x_cyc), 32'd1);
        chk("t1_xadr", x_adr, 32'h0010_0040);
        chk("t1_grant", 32'(grant), 32'b010);
        chk("t1_busy", 32'(busy), 32'd1);
        for (int k = 0; k < 4; k++) begin
            #1 chk("t1_wait_ack", 32'(req_ack), 32'd0);
            nxt();
        end
        x_ack = 1'b1;
        x_rdt = 32'hDEAD_BEEF;
        #1 chk("t1_ack", 32'(req_ack), 32'b010);
        chk("t1_rdt", req_rdt[63:32], 32'hDEAD_BEEF);
        chk("t1_rdt_p0", req_rdt[31:0], 32'd0);
        chk("t1_err", 32'(timeout_err), 32'd0);
        nxt();
        x_ack = 1'b0;
        req_cyc = 3'b000;
        #1 chk("t1_done_xcyc", 32'(x_cyc), 32'd0);
        chk("t1_done_busy", 32'(busy), 32'd1);
        chk("t1_done_grant", 32'(grant), 32'd0);
        chk("t1_done_ack", 32'(req_ack), 32'd0);
        nxt();
        #1 chk("t1_idle", 32'(busy), 32'd0);

        // Ports 0 and 2 together: port 0 first, port 2 three cycles after ack
        req_cyc = 3'b101;
        req_adr[31:0] = 32'h0000_1000;
        req_adr[95:64] = 32'h0020_2000;
        nxt();
        chk("t2_grant0", 32'(grant), 32'b001);
        chk("t2_xadr0", x_adr, 32'h0000_1000);
        x_ack = 1'b1;
        x_rdt = 32'h1111_0000;
        #1 chk("t2_ack0", 32'(req_ack), 32'b001);
        nxt();
        x_ack = 1'b0;
        req_cyc = 3'b100;
        #1 chk("t2_t1_xcyc", 32'(x_cyc), 32'd0);
        nxt();
        #1 chk("t2_t2_xcyc", 32'(x_cyc), 32'd0);
        chk("t2_t2_busy", 32'(busy), 32'd0);
        nxt();
        chk("t2_t3_xcyc", 32'(x_cyc), 32'd1);
        chk("t2_grant2", 32'(grant), 32'b100);
        chk("t2_xadr2", x_adr, 32'h0020_2000);
        x_ack = 1'b1;
        x_rdt = 32'h2222_0000;
        #1 chk("t2_ack2", 32'(req_ack), 32'b100);
        chk("t2_rdt2", req_rdt[95:64], 32'h2222_0000);
        nxt();
        x_ack = 1'b0;
        req_cyc = 3'b000;
        nxt();

        // Starvation: port 0 continuous, port 1 waiting
        req_cyc = 3'b011;
        req_adr[31:0] = 32'h0000_0100;
        req_adr[63:32] = 32'h0000_0200;
        for (int n = 0; n < 6; n++) xact($sformatf("st%0d", n), sq[n], 32'hA000_0000 + 32'(n));
        req_cyc = 3'b000;
        nxt();

        // Asynchronous reset mid-BUSY, then starve counter must be back at 0
        req_cyc = 3'b011;
        nxt();
        chk("rs_grant_pre", 32'(grant), 32'b001);
        x_ack = 1'b1;
        x_rdt = 32'h3333_3333;
        #1 chk("rs_ack_pre", 32'(req_ack), 32'b001);
        #1 wb_rst = 1'b1;
        #1 chk("rs_xcyc", 32'(x_cyc), 32'd0);
        chk("rs_grant", 32'(grant), 32'd0);
        chk("rs_busy", 32'(busy), 32'd0);
        chk("rs_ack", 32'(req_ack), 32'd0);
        x_ack = 1'b0;
        nxt();
        nxt();
        wb_rst = 1'b0;
        for (int n = 0; n < 5; n++) xact($sformatf("rs%0d", n), (n == 4) ? 3'b010 : 3'b001, 32'hB000_0000 + 32'(n));
        req_cyc = 3'b000;
        nxt();

        // Watchdog abort at BUSY cycle 16
        req_cyc = 3'b100;
        req_adr[95:64] = 32'h0030_0000;
        nxt();
        for (int k = 0; k < 16; k++) begin
            #1 chk("to_err_early", 32'(timeout_err), 32'd0);
            chk("to_ack_early", 32'(req_ack), 32'd0);
            nxt();
        end
        #1 chk("to_ack", 32'(req_ack), 32'b100);
        chk("to_rdt", req_rdt[95:64], 32'hFFFF_FFFF);
        chk("to_err", 32'(timeout_err), 32'd1);
        chk("to_xcyc_hold", 32'(x_cyc), 32'd1);
        nxt();
        req_cyc = 3'b000;
        #1 chk("to_done_xcyc", 32'(x_cyc), 32'd0);
        chk("to_done_err", 32'(timeout_err), 32'd0);
        chk("to_done_ack", 32'(req_ack), 32'd0);
        nxt();

        // x_ack coinciding with the timeout: normal completion wins
        req_cyc = 3'b100;
        nxt();
        for (int k = 0; k < 16; k++) nxt();
        x_ack = 1'b1;
        x_rdt = 32'h1234_5678;
        #1 chk("tc_ack", 32'(req_ack), 32'b100);
        chk("tc_rdt", req_rdt[95:64], 32'h1234_5678);
        chk("tc_err", 32'(timeout_err), 32'd0);
        nxt();
        x_ack = 1'b0;
        req_cyc = 3'b000;
        nxt();

        // Stray x_ack while idle is ignored
        x_ack = 1'b1;
        x_rdt = 32'h5555_5555;
        #1 chk("stray_ack", 32'(req_ack), 32'd0);
        chk("stray_rdt", 32'(|req_rdt), 32'd0);
        nxt();
        x_ack = 1'b0;
        #1 chk("stray_busy", 32'(busy), 32'd0);

        // Abandon: port 1 drops cyc two cycles into BUSY
        req_cyc = 3'b010;
        req_adr[63:32] = 32'h0040_0000;
        nxt();
        nxt();
        nxt();
        req_cyc = 3'b000;
        #1 chk("ab_xcyc", 32'(x_cyc), 32'd1);
        chk("ab_grant", 32'(grant), 32'b010);
        nxt();
        nxt();
        x_ack = 1'b1;
        x_rdt = 32'h6666_6666;
        #1 chk("ab_ack", 32'(req_ack), 32'd0);
        chk("ab_rdt", 32'(|req_rdt), 32'd0);
        chk("ab_xcyc_at_ack", 32'(x_cyc), 32'd1);
        nxt();
        x_ack = 1'b0;
        #1 chk("ab_done_busy", 32'(busy), 32'd1);
        chk("ab_done_xcyc", 32'(x_cyc), 32'd0);
        nxt();
        #1 chk("ab_idle", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ibus_sched.md
Name: ibus_sched

Overview:
- N-requester scheduler sharing the single SPI-flash ibus controller (XiP fetch engine) between the CPU ibus, the dbus-side flash reader and future masters (e.g. a flash-to-RAM copy engine).
- Requester 0 has fixed priority, with a starvation guard so lower ports still get served.
- A watchdog aborts transactions the controller never acks.
- Sits between the requesters and the ibus SPI controller; its data/ack outputs are zero when idle, for OR-combining.

Parameters:
- N, 3, number of requesters (2..8); index 0 is the CPU.
- MAX_STARVE, 4, consecutive port-0 grants allowed while another port waits (1..15).
- TIMEOUT, 1023, cycles in BUSY without x_ack before abort; 0 disables the watchdog.

Ports:
- wb_clk  in  1  clock
- wb_rst  in  1  reset; asynchronous and active-high
- req_cyc  in  N  per-requester cycle request
- req_adr  in  32*N  per-requester address; port i at [32*i+31:32*i]
- req_ack  out  N  per-requester ack, 1-cycle pulse
- req_rdt  out  32*N  per-requester read data; zero except in the ack cycle
- x_cyc  out  1  cycle to the SPI controller
- x_adr  out  32  address to the SPI controller
- x_ack  in  1  controller ack
- x_rdt  in  32  controller read data
- grant  out  N  one-hot owner, held through BUSY; 0 otherwise
- busy  out  1  high in BUSY and DONE
- timeout_err  out  1  1-cycle pulse on watchdog abort

Behaviour:
- Reset values: all outputs 0; state IDLE; starve counter 0; watchdog counter 0.
- States: IDLE, BUSY, DONE.
- IDLE, when any req_cyc is high:
  - Choose a winner. Normally the lowest index wins.
  - If the starve counter equals MAX_STARVE and any port >0 is requesting, the lowest-indexed requesting port >0 wins.
  - Register grant and x_adr (copied from the winner's req_adr), set x_cyc=1, go to BUSY.
  - x_cyc therefore rises one cycle after the request is seen.
- Starve counter:
  - Increments (saturating) when port 0 is granted while any other port is requesting.
  - Clears when any port >0 is granted.
  - Unchanged otherwise.
- BUSY:
  - x_cyc=1; x_adr is held stable.
  - On x_ack: combinationally req_ack[g]=1 and req_rdt slice g = x_rdt in that same cycle. Register x_cyc=0, go to DONE.
  - Watchdog counts BUSY cycles from 0. On reaching TIMEOUT with no x_ack:
    - req_ack[g]=1 with rdt 32'hFFFF_FFFF.
    - timeout_err=1.
    - x_cyc drops; go to DONE.
  - If x_ack and timeout coincide, x_ack wins: normal completion, no error.
- Requester drops req_cyc during BUSY (abandoned):
  - x_cyc stays high until x_ack or timeout, because the SPI transfer cannot be cut.
  - The completing ack/rdt is discarded: req_ack stays 0.
- DONE: one dead cycle with x_cyc=0 so the requester can deassert cyc. grant=0, go to IDLE.
  - Minimum back-to-back spacing: ack at cycle t, next x_cyc at t+3 (DONE at t+1, IDLE arbitration at t+2).
- x_ack while not in BUSY is ignored; no req_ack is generated.
- Asynchronous reset mid-transaction clears everything immediately. The controller sees x_cyc fall and must tolerate the abort.
- grant is always one-hot or zero; req_ack has at most one bit set.

Decomposition:
- Shared package holds:
  - State encoding constants: IDLE=2'd0, BUSY=2'd1, DONE=2'd2.
  - Abort data constant TIMEOUT_RDT=32'hFFFF_FFFF.
- One sub-module, `prio_pick`, is natural: combinational N-bit fixed-priority picker with a mask input (used for the ">0 only" starvation mode), outputting a one-hot vector.
- Watchdog and starve counters stay inline.

Test Plan:
- Single request, port 1: req_cyc=3'b010, adr 0x0010_0040; controller acks after 5 cycles with 0xDEADBEEF -> x_cyc rises 1 cycle after request, x_adr=0x0010_0040, req_ack[1] pulses with rdt 0xDEADBEEF, grant=3'b010 during BUSY.
- Simultaneous requests from ports 0 and 2 -> port 0 served first; after DONE, port 2 granted with x_cyc rising 3 cycles after port-0 ack.
- Starvation: port 0 re-requests continuously while port 1 holds req_cyc, MAX_STARVE=4 -> four port-0 grants, fifth grant to port 1, counter clears, next grant port 0.
- Timeout: TIMEOUT=16, no x_ack -> at BUSY cycle 16 req_ack[g]=1 with rdt 0xFFFFFFFF, timeout_err pulses once, x_cyc falls; x_ack arriving exactly at cycle 16 instead gives normal data and no err.
- Abandon: port 1 drops req_cyc 2 cycles into BUSY -> x_cyc held until x_ack, req_ack stays 0, state returns to IDLE via DONE.
- Reset: assert wb_rst mid-BUSY (between clock edges) -> x_cyc, grant, busy, req_ack go 0 immediately; after release, a new request is served normally with the starve counter at 0.
